// File: rtl/vga_scanout.sv
// Raster timing generator and RGB332 framebuffer scanout, outputs aligned to a RD_LAT-clock video RAM.
// Defining SCANOUT_LINE_IRQ_EN adds the irq_line input and the line_irq raster-compare pulse.
module vga_scanout #(
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int ADDR_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int PIX_SHIFT = 2,
    parameter int FB_STRIDE = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fb_base,
    output logic [ADDR_W-1:0] vpu_addr,
    input  logic [7:0]        vpu_data,
    output logic [3:0]        vgaR,
    output logic [3:0]        vgaG,
    output logic [3:0]        vgaB,
    output logic              vgaH,
    output logic              vgaV,
    output logic              vga_de,
`ifdef SCANOUT_LINE_IRQ_EN
    input  logic [10:0]       irq_line,
    output logic              line_irq,
`endif
    output logic              frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W     = $clog2(H_TOTAL);
    localparam int VC_W     = $clog2(V_TOTAL);
    localparam int PIX_MASK = (1 << PIX_SHIFT) - 1;

    // Control flags travelling alongside the RAM read; sync fields hold pin levels.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } stage_t;

    localparam stage_t STAGE_RST = '{de: 1'b0, hs: ~HSYNC_POL, vs: ~VSYNC_POL, fs: 1'b0};

    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic [VC_W-1:0]   vcnt_q, vcnt_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] eff_base;
    logic              h_wrap, v_wrap, active_line, active, hsync, vsync, frame_top;
    stage_t            stage_d;
    stage_t            pipe_q [RD_LAT+1];
    logic [11:0]       rgb_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        hcnt_d      = hcnt_q + 1'b1;
        vcnt_d      = vcnt_q;
        h_wrap      = (hcnt_q == HC_W'(H_TOTAL - 1));
        v_wrap      = (vcnt_q == VC_W'(V_TOTAL - 1));
        frame_top   = (hcnt_q == '0) && (vcnt_q == '0);
        active_line = int'(vcnt_q) < V_ACTIVE;
        active      = active_line && (int'(hcnt_q) < H_ACTIVE);
        hsync       = (int'(hcnt_q) >= H_ACTIVE + H_FP) && (int'(hcnt_q) < H_ACTIVE + H_FP + H_SYNC);
        vsync       = (int'(vcnt_q) >= V_ACTIVE + V_FP) && (int'(vcnt_q) < V_ACTIVE + V_FP + V_SYNC);

        if (h_wrap) begin
            hcnt_d = '0;
            vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
        end

        // The first dot of a frame must already fetch from the new base, so bypass the register.
        eff_base   = frame_top ? fb_base : row_base_q;
        row_base_d = eff_base;
        if (h_wrap && active_line && ((int'(vcnt_q) & PIX_MASK) == PIX_MASK)) begin
            row_base_d = eff_base + ADDR_W'(FB_STRIDE);
        end

        vpu_addr = active ? eff_base + ADDR_W'(hcnt_q >> PIX_SHIFT) : eff_base;

        stage_d.de = active;
        stage_d.hs = hsync ? HSYNC_POL : ~HSYNC_POL;
        stage_d.vs = vsync ? VSYNC_POL : ~VSYNC_POL;
        stage_d.fs = frame_top;
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            row_base_q <= '0;
            rgb_q      <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                pipe_q[i] <= STAGE_RST;
            end
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            row_base_q <= row_base_d;
            pipe_q[0]  <= stage_d;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            // RAM data for a dot arrives together with stage RD_LAT-1 of that dot's flags.
            rgb_q <= pipe_q[RD_LAT-1].de
                   ? {vpu_data[7:5], vpu_data[7], vpu_data[4:2], vpu_data[4], vpu_data[1:0], vpu_data[1:0]}
                   : 12'h000;
        end
    end

    assign vga_de           = pipe_q[RD_LAT].de;
    assign vgaH             = pipe_q[RD_LAT].hs;
    assign vgaV             = pipe_q[RD_LAT].vs;
    assign frame_start      = pipe_q[RD_LAT].fs;
    assign {vgaR, vgaG, vgaB} = rgb_q;

`ifdef SCANOUT_LINE_IRQ_EN
    // Raster compare taps the live counters, ahead of the pixel pipeline.
    assign line_irq = !reset && (int'(hcnt_q) == H_ACTIVE) && (int'(vcnt_q) == int'(irq_line));
`endif

endmodule
